// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the round-robin memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int ARB_AW      = 14;
    localparam int ARB_DW      = 16;
    localparam int ARB_TIMEOUT = 64;

    // Channel index width; a single channel still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set req bit at or above ptr, wrapping
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDW    = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    ptr,
    output logic [IDW-1:0]    gnt,
    output logic              any_req
);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        int idx;
        gnt     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (req[idx]) begin
                gnt     = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel round-robin SRAM arbiter with timeout; MEM_ARB_STATS_EN adds grant/timeout counters
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT,
    parameter int IDW     = id_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    we,
    input  logic [NUM_CH*AW-1:0] addr,
    input  logic [NUM_CH*DW-1:0] wdata,
    output logic [NUM_CH-1:0]    resp,
    output logic [DW-1:0]        rdata,
    output logic                 resp_err,
    output logic                 busy,
    output logic [IDW-1:0]       gnt_id,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
`ifdef MEM_ARB_STATS_EN
    output logic [NUM_CH*16-1:0] grant_cnt,
    output logic [15:0]          timeout_cnt,
`endif
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_resp
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;
    logic            hold_we;
    logic [IDW-1:0]  pick_gnt;
    logic            pick_any;
    logic [AW-1:0]   addr_a  [NUM_CH];
    logic [DW-1:0]   wdata_a [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*AW +: AW];
        assign wdata_a[i] = wdata[i*DW +: DW];
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDW    (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .any_req (pick_any)
    );

    assign busy = (state != IDLE);

    // mem_addr/mem_wdata double as the holding registers for the granted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            hold_we   <= 1'b0;
            gnt_id    <= '0;
            resp      <= '0;
            rdata     <= '0;
            resp_err  <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            resp     <= '0;
            rdata    <= '0;
            resp_err <= 1'b0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_id    <= pick_gnt;
                        hold_we   <= we[pick_gnt];
                        mem_addr  <= addr_a[pick_gnt];
                        mem_wdata <= wdata_a[pick_gnt];
                        mem_re    <= ~we[pick_gnt];
                        mem_we    <= we[pick_gnt];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion in the final WAIT cycle beats the timeout.
                    if (mem_resp) begin
                        rdata          <= hold_we ? '0 : mem_rdata;
                        resp[gnt_id]   <= 1'b1;
                        state          <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        cnt            <= cnt + 1'b1;
                        resp_err       <= 1'b1;
                        resp[gnt_id]   <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (gnt_id == IDW'(NUM_CH - 1)) ptr <= '0;
                    else                            ptr <= gnt_id + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] gcnt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
        assign grant_cnt[i*16 +: 16] = gcnt[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) gcnt[i] <= '0;
            timeout_cnt <= '0;
        end else if (state == RESP) begin
            if (gcnt[gnt_id] != 16'hFFFF) gcnt[gnt_id] <= gcnt[gnt_id] + 16'd1;
            if (resp_err && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-channel memory arbiter: the successor to the fixed four-request memory subsystem front end.
- Accepts read/write requests from NUM_CH processor memory interfaces and grants them round-robin, one at a time.
- Issues one operation per grant to a single-port SRAM and returns read data and a response pulse to the granted channel.
- Adds a response timeout and an error flag; the fixed-channel version has neither.

Parameters:
- NUM_CH, 4: number of requesting channels, 1..16.
- AW, 14: address width.
- DW, 16: data width, both read and write.
- TIMEOUT, 64: maximum cycles spent in WAIT before the arbiter aborts the access.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_CH  per-channel request; held until the matching resp bit.
- we  in  NUM_CH  per-channel op: 1 = write, 0 = read.
- addr  in  NUM_CH*AW  per-channel address; channel i occupies [i*AW +: AW].
- wdata  in  NUM_CH*DW  per-channel write data; channel i occupies [i*DW +: DW].
- resp  out  NUM_CH  one-cycle done pulse to the granted channel.
- rdata  out  DW  read data, valid only while any resp bit is high.
- resp_err  out  1  high with resp when the access timed out.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  $clog2(NUM_CH) (min 1)  currently granted channel.
- mem_re  out  1  SRAM read strobe, one cycle.
- mem_we  out  1  SRAM write strobe, one cycle.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data, sampled when mem_resp is high.
- mem_resp  in  1  SRAM completion, at least 1 cycle after a strobe.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM to IDLE, round-robin pointer to 0, timeout counter to 0. An in-flight SRAM operation is abandoned and no resp is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, select the first set bit scanning upward from ptr, wrapping at NUM_CH.
  - Latch channel id, we, addr and wdata into holding registers; go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE:
  - Drive mem_re (we=0) or mem_we (we=1) for exactly one cycle, with mem_addr/mem_wdata taken from the holding registers.
  - Clear the counter; go to WAIT.
- WAIT:
  - On mem_resp: capture mem_rdata (reads only; writes return 0) and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT, set the timeout flag and go to RESP with rdata = 0.
  - mem_resp arriving in the same cycle as the timeout wins; no error is reported.
- RESP:
  - Pulse resp[gnt] for one cycle, with rdata and resp_err valid.
  - Set ptr = (gnt+1) mod NUM_CH; go to IDLE.
- Latency: request seen in IDLE at cycle 0 gives the strobe at cycle 1, and resp at cycle 3 when mem_resp arrives at cycle 2. Minimum latency is 3 cycles.
- Back-to-back: a channel holding req after its resp is eligible again in the next IDLE, but only after the others in round-robin order.
- Request inputs are ignored outside IDLE. Changes to addr/wdata/we after the grant have no effect. Dropping req mid-transaction does not abort; the resp pulse is still issued.
- A mem_resp seen outside WAIT is ignored.
- NUM_CH=1: the pointer stays at 0 and gnt_id is a 1-bit constant 0.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds output grant_cnt (NUM_CH*16) holding per-channel saturating 16-bit counters that increment on every resp, and output timeout_cnt (16), saturating. Both clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - default constants ARB_AW=14, ARB_DW=16, ARB_TIMEOUT=64.
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: gnt index, any_req.

Test Plan:
- Single read: preload addr 0x0010 = 0xBEEF, ch2 read of 0x0010, mem_resp 1 cycle after the strobe -> resp[2] at cycle 3, rdata=0xBEEF, resp_err=0.
- Fairness: all 4 channels hold req continuously, starting from ptr=0 -> grant order 0,1,2,3,0; no channel is granted twice before every other requester has been granted.
- Write then read: ch1 writes 0x1234 to 0x3FFF, then ch3 reads 0x3FFF -> mem_we seen with addr 0x3FFF, ch3 rdata=0x1234.
- Timeout: mem_resp held low, TIMEOUT=64 -> resp[0] 64 WAIT cycles after the strobe, with resp_err=1 and rdata=0. A mem_resp arriving 5 cycles later is ignored.
- Reset mid-WAIT: reset_n low during ch1 WAIT -> all outputs 0 immediately, no resp[1], ptr=0. After release, ch1 and ch2 both requesting -> ch1 is granted.
- Stats (MEM_ARB_STATS_EN): 3 completed ch0 accesses plus 1 timeout -> grant_cnt[ch0]=4, timeout_cnt=1.
